// File: rtl/interrupt_controller_pkg.sv
// Shared RISC-V interrupt types: mip bit indices, interrupt codes, privilege
// levels and the controller state encoding.
package interrupt_controller_pkg;

    typedef logic [11:0] irq_vec_t;

    localparam int MIP_MEIP = 11;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MSIP = 3;
    localparam int MIP_SEIP = 9;
    localparam int MIP_STIP = 5;
    localparam int MIP_SSIP = 1;

    // Machine-level sources can never be delegated.
    localparam irq_vec_t MACHINE_ONLY_MASK = 12'h888;
    // The only pending bits software may set from the CSR file.
    localparam irq_vec_t SW_PENDING_MASK   = 12'h222;

    typedef enum logic [3:0] {
        IRQ_NONE        = 4'd0,
        IRQ_S_SOFTWARE  = 4'd1,
        IRQ_M_SOFTWARE  = 4'd3,
        IRQ_S_TIMER     = 4'd5,
        IRQ_M_TIMER     = 4'd7,
        IRQ_S_EXTERNAL  = 4'd9,
        IRQ_M_EXTERNAL  = 4'd11
    } interrupt_code_e;

    typedef enum logic [1:0] {
        PRIV_USER       = 2'b00,
        PRIV_SUPERVISOR = 2'b01,
        PRIV_MACHINE    = 2'b11
    } privilege_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_COOLDOWN = 2'd2
    } int_ctrl_state_e;

endpackage

// File: rtl/interrupt_controller_sync.sv
// Multi-flop synchronizer for one asynchronous level-sensitive interrupt pin.
module interrupt_controller_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[DEPTH-2:0], d};
        end
    end

    assign q = sync_reg[DEPTH-1];

endmodule

// File: rtl/interrupt_controller.sv
// Builds the mip image, applies enable/delegation/privilege rules and holds the
// highest-priority takeable interrupt as a stable request until ack or withdrawal.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int COOLDOWN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        irqMachineExternal,
    input  logic        irqSupervisorExternal,
    input  logic        irqMachineTimer,
    input  logic        irqMachineSoftware,
    input  logic [11:0] csrMipSw,
    input  logic [11:0] csrMie,
    input  logic [11:0] csrMideleg,
    input  logic        mstatusMie,
    input  logic        mstatusSie,
    input  logic [1:0]  privilege,
    input  logic        trapAck,
    output logic        trapReq,
    output logic [3:0]  trapCode,
    output logic [1:0]  trapTarget,
    output logic [11:0] mip
);

    localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [1:0] ext_pins;
    logic [1:0] ext_synced;

    assign ext_pins = {irqSupervisorExternal, irqMachineExternal};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        interrupt_controller_sync #(.DEPTH(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rstN (rstN),
            .d    (ext_pins[gi]),
            .q    (ext_synced[gi])
        );
    end

    function automatic privilege_e target_of(input interrupt_code_e code, input irq_vec_t deleg);
        if (deleg[code] && !MACHINE_ONLY_MASK[code])
            return PRIV_SUPERVISOR;
        return PRIV_MACHINE;
    endfunction

    function automatic irq_vec_t takeable_mask(input irq_vec_t pend, input irq_vec_t deleg,
                                               input logic m_ie, input logic s_ie,
                                               input privilege_e priv);
        logic     m_ok;
        logic     s_ok;
        irq_vec_t to_s;
        m_ok = (priv != PRIV_MACHINE) || m_ie;
        s_ok = (priv == PRIV_USER) || ((priv == PRIV_SUPERVISOR) && s_ie);
        to_s = deleg & ~MACHINE_ONLY_MASK;
        return pend & ((to_s & {12{s_ok}}) | (~to_s & {12{m_ok}}));
    endfunction

    function automatic interrupt_code_e select_code(input irq_vec_t cand);
        if (cand[MIP_MEIP])      return IRQ_M_EXTERNAL;
        else if (cand[MIP_MSIP]) return IRQ_M_SOFTWARE;
        else if (cand[MIP_MTIP]) return IRQ_M_TIMER;
        else if (cand[MIP_SEIP]) return IRQ_S_EXTERNAL;
        else if (cand[MIP_SSIP]) return IRQ_S_SOFTWARE;
        else if (cand[MIP_STIP]) return IRQ_S_TIMER;
        return IRQ_NONE;
    endfunction

    irq_vec_t        mip_reg, mip_next;
    int_ctrl_state_e state_reg, state_next;
    interrupt_code_e code_reg, code_next;
    privilege_e      target_reg, target_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    privilege_e      priv;
    irq_vec_t        cand;
    interrupt_code_e best_code;
    logic            latched_ok;
    logic            unused_sw;

    assign priv      = privilege_e'(privilege);
    assign unused_sw = ^(csrMipSw & ~SW_PENDING_MASK);

    always_comb begin
        mip_next           = '0;
        mip_next[MIP_MEIP] = ext_synced[0];
        mip_next[MIP_MTIP] = irqMachineTimer;
        mip_next[MIP_MSIP] = irqMachineSoftware;
        mip_next[MIP_SEIP] = ext_synced[1] | csrMipSw[MIP_SEIP];
        mip_next[MIP_STIP] = csrMipSw[MIP_STIP];
        mip_next[MIP_SSIP] = csrMipSw[MIP_SSIP];
    end

    assign cand      = takeable_mask(mip_reg & csrMie, csrMideleg, mstatusMie, mstatusSie, priv);
    assign best_code = select_code(cand);
    // A delegation change that moves the latched source to another target also withdraws it.
    assign latched_ok = cand[code_reg] && (target_of(code_reg, csrMideleg) == target_reg);

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        target_next = target_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|cand) begin
                    code_next   = best_code;
                    target_next = target_of(best_code, csrMideleg);
                    state_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trapAck) begin
                    state_next = ST_COOLDOWN;
                    cnt_next   = '0;
                end else if (!latched_ok) begin
                    state_next = ST_IDLE;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_reg == CNT_LAST)
                    state_next = ST_IDLE;
                else
                    cnt_next = cnt_reg + 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mip_reg    <= '0;
            state_reg  <= ST_IDLE;
            code_reg   <= IRQ_NONE;
            target_reg <= PRIV_MACHINE;
            cnt_reg    <= '0;
        end else begin
            mip_reg    <= mip_next;
            state_reg  <= state_next;
            code_reg   <= code_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign trapReq    = (state_reg == ST_REQ);
    assign trapCode   = code_reg;
    assign trapTarget = target_reg;
    assign mip        = mip_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed checks of the interrupt controller: latency, priority, delegation,
// withdrawal versus ack, synchronizer depth and asynchronous reset.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rstN;
    logic        irqMachineExternal, irqSupervisorExternal;
    logic        irqMachineTimer, irqMachineSoftware;
    logic [11:0] csrMipSw, csrMie, csrMideleg;
    logic        mstatusMie, mstatusSie;
    logic [1:0]  privilege;
    logic        trapAck;
    logic        trapReq;
    logic [3:0]  trapCode;
    logic [1:0]  trapTarget;
    logic [11:0] mip;

    int check_cnt = 0;
    int fail_cnt  = 0;

    interrupt_controller #(.SYNC_STAGES(2), .COOLDOWN_CYCLES(1)) dut (
        .clk                   (clk),
        .rstN                  (rstN),
        .irqMachineExternal    (irqMachineExternal),
        .irqSupervisorExternal (irqSupervisorExternal),
        .irqMachineTimer       (irqMachineTimer),
        .irqMachineSoftware    (irqMachineSoftware),
        .csrMipSw              (csrMipSw),
        .csrMie                (csrMie),
        .csrMideleg            (csrMideleg),
        .mstatusMie            (mstatusMie),
        .mstatusSie            (mstatusSie),
        .privilege             (privilege),
        .trapAck               (trapAck),
        .trapReq               (trapReq),
        .trapCode              (trapCode),
        .trapTarget            (trapTarget),
        .mip                   (mip)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstN                  = 1'b0;
        irqMachineExternal    = 1'b0;
        irqSupervisorExternal = 1'b0;
        irqMachineTimer       = 1'b0;
        irqMachineSoftware    = 1'b0;
        csrMipSw              = '0;
        csrMie                = '0;
        csrMideleg            = '0;
        mstatusMie            = 1'b0;
        mstatusSie            = 1'b0;
        privilege             = 2'b11;
        trapAck               = 1'b0;
        tick(2);
        rstN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Timer: latency, ack, cooldown, level re-request
        apply_reset();
        check_val("rst_req", 32'(trapReq), 32'h0);
        check_val("rst_code", 32'(trapCode), 32'h0);
        check_val("rst_target", 32'(trapTarget), 32'h3);
        check_val("rst_mip", 32'(mip), 32'h0);
        privilege = 2'b11; mstatusMie = 1'b1; csrMie = 12'h080; irqMachineTimer = 1'b1;
        tick(1);
        check_val("tmr_c1_req", 32'(trapReq), 32'h0);
        check_val("tmr_c1_mip", 32'(mip), 32'h080);
        tick(1);
        check_val("tmr_c2_req", 32'(trapReq), 32'h1);
        check_val("tmr_c2_code", 32'(trapCode), 32'h7);
        check_val("tmr_c2_target", 32'(trapTarget), 32'h3);
        tick(2);
        trapAck = 1'b1;
        tick(1);
        trapAck = 1'b0;
        check_val("tmr_c5_req", 32'(trapReq), 32'h0);
        tick(1);
        check_val("tmr_c6_req", 32'(trapReq), 32'h0);
        tick(1);
        check_val("tmr_c7_req", 32'(trapReq), 32'h1);
        check_val("tmr_c7_code", 32'(trapCode), 32'h7);

        // Priority: external over software, then software after external drops
        apply_reset();
        csrMie = 12'h808; irqMachineSoftware = 1'b1; irqMachineExternal = 1'b1;
        tick(4);
        check_val("pri_mip", 32'(mip), 32'h808);
        check_val("pri_masked_req", 32'(trapReq), 32'h0);
        mstatusMie = 1'b1;
        tick(1);
        check_val("pri_req", 32'(trapReq), 32'h1);
        check_val("pri_code_b", 32'(trapCode), 32'hb);
        irqMachineExternal = 1'b0;
        tick(3);
        check_val("pri_mip_drop", 32'(mip), 32'h008);
        check_val("pri_held_code", 32'(trapCode), 32'hb);
        trapAck = 1'b1;
        tick(1);
        trapAck = 1'b0;
        check_val("pri_ack_req", 32'(trapReq), 32'h0);
        tick(2);
        check_val("pri_next_req", 32'(trapReq), 32'h1);
        check_val("pri_code_3", 32'(trapCode), 32'h3);

        // Delegated supervisor external: blocked in Machine, taken in User
        apply_reset();
        csrMie = 12'h200; csrMideleg = 12'h200; mstatusMie = 1'b1; mstatusSie = 1'b1;
        irqSupervisorExternal = 1'b1;
        tick(6);
        check_val("sei_mip", 32'(mip), 32'h200);
        check_val("sei_mmode_req", 32'(trapReq), 32'h0);
        privilege = 2'b00;
        tick(1);
        check_val("sei_user_req", 32'(trapReq), 32'h1);
        check_val("sei_code", 32'(trapCode), 32'h9);
        check_val("sei_target", 32'(trapTarget), 32'h1);

        // Withdraw on mie clear, and ack winning over simultaneous loss
        apply_reset();
        mstatusMie = 1'b1; csrMie = 12'h080; irqMachineTimer = 1'b1;
        tick(2);
        check_val("wd_req", 32'(trapReq), 32'h1);
        csrMie = 12'h000;
        tick(1);
        check_val("wd_drop", 32'(trapReq), 32'h0);
        tick(1);
        check_val("wd_idle", 32'(trapReq), 32'h0);
        csrMie = 12'h080;
        tick(1);
        check_val("wd_rereq", 32'(trapReq), 32'h1);
        csrMie = 12'h000; trapAck = 1'b1;
        tick(1);
        trapAck = 1'b0; csrMie = 12'h080;
        check_val("ackwin_c1", 32'(trapReq), 32'h0);
        tick(1);
        check_val("ackwin_cooldown", 32'(trapReq), 32'h0);
        tick(1);
        check_val("ackwin_rereq", 32'(trapReq), 32'h1);

        // External pin pulse through the two-stage synchronizer
        apply_reset();
        mstatusMie = 1'b1; csrMie = 12'h800;
        irqMachineExternal = 1'b1;
        tick(1);
        irqMachineExternal = 1'b0;
        tick(1);
        check_val("ext_c2_mip", 32'(mip), 32'h000);
        tick(1);
        check_val("ext_c3_mip", 32'(mip), 32'h800);
        check_val("ext_c3_req", 32'(trapReq), 32'h0);
        tick(1);
        check_val("ext_c4_req", 32'(trapReq), 32'h1);
        check_val("ext_c4_code", 32'(trapCode), 32'hb);
        tick(1);
        check_val("ext_c5_withdraw", 32'(trapReq), 32'h0);

        // Asynchronous reset in the middle of a request
        apply_reset();
        mstatusMie = 1'b1; csrMie = 12'h080; irqMachineTimer = 1'b1;
        tick(2);
        check_val("arst_pre_req", 32'(trapReq), 32'h1);
        #3;
        rstN = 1'b0;
        #1;
        check_val("arst_req", 32'(trapReq), 32'h0);
        check_val("arst_mip", 32'(mip), 32'h0);
        check_val("arst_code", 32'(trapCode), 32'h0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        tick(1);
        check_val("arst_rel_c1_req", 32'(trapReq), 32'h0);
        tick(1);
        check_val("arst_rel_c2_req", 32'(trapReq), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects RISC-V interrupt sources and merges them into a mip image.
- Applies enables, delegation and privilege rules, then selects the highest-priority takeable interrupt.
- Presents it to the pipeline's trap unit as a stable, held request carrying an InterruptCode and a target Privilege.
- Sits between the interrupt pins / CSR file and the trap-entry logic.

Parameters:
SYNC_STAGES, 2, flop depth of the synchronizers on asynchronous external interrupt pins (min 2)
COOLDOWN_CYCLES, 1, idle cycles after ack before a new request (lets mstatus/privilege updates settle; min 1)

Ports:
clk  input  1  clock
rstN  input  1  reset, asynchronous, active-low
irqMachineExternal  input  1  asynchronous pin, level-sensitive (MEIP)
irqSupervisorExternal  input  1  asynchronous pin, level-sensitive (SEIP)
irqMachineTimer  input  1  synchronous, from timer (MTIP)
irqMachineSoftware  input  1  synchronous, from msip register (MSIP)
csrMipSw  input  12  software-writable pending bits from CSR file; only SSIP[1], STIP[5], SEIP[9] used
csrMie  input  12  mie
csrMideleg  input  12  mideleg
mstatusMie  input  1  mstatus.MIE
mstatusSie  input  1  mstatus.SIE
privilege  input  2  current Privilege
trapAck  input  1  trap unit has taken the interrupt this cycle
trapReq  output  1  interrupt request valid
trapCode  output  4  InterruptCode of request
trapTarget  output  2  Privilege the trap is taken into (Machine or Supervisor)
mip  output  12  registered pending image, for CSR reads

Behaviour:
- Reset (rstN low, async): trapReq=0, trapCode=0, trapTarget=Privilege_Machine, mip=0, synchronizers cleared, state=IDLE. Reset mid-request drops trapReq immediately.
- Synchronizers: each external pin passes through SYNC_STAGES flops.
- mip register, updated every cycle:
  - bit11 = synced MEI; bit7 = MTI; bit3 = MSI.
  - bit9 = synced SEI | csrMipSw[9]; bit5 = csrMipSw[5]; bit1 = csrMipSw[1].
  - All other bits 0. User-level codes are never generated.
- Candidate set: pend = mip & csrMie.
- Target of bit i: Supervisor if csrMideleg[i]; else Machine. Machine-level bits 11/7/3 always target Machine regardless of mideleg.
- Takeable rules:
  - Machine target: privilege<Machine, or mstatusMie.
  - Supervisor target: privilege==User, or (privilege==Supervisor and mstatusSie). Never taken while privilege==Machine.
- Fixed priority, highest first: 11, 3, 7, 9, 1, 5. Combinational encoder on registered mip and current inputs.
- FSM states: IDLE, REQ, COOLDOWN.
  - IDLE: if any takeable, register code/target and go to REQ. trapReq=1 from the next cycle.
  - REQ: trapReq=1; trapCode/trapTarget held stable with no preemption by higher-priority arrivals.
    - trapAck -> COOLDOWN, trapReq=0 next cycle.
    - Latched interrupt no longer takeable (source dropped, or mie/mideleg/MIE/SIE/privilege changed) and no trapAck -> withdraw, trapReq=0, go to IDLE.
    - trapAck in the same cycle as loss of takeability: ack wins (COOLDOWN).
  - COOLDOWN: count COOLDOWN_CYCLES, then IDLE. No request during cooldown.
- trapAck while not in REQ is ignored.
- Latency:
  - Synchronous source to trapReq: 2 cycles (mip register + FSM register).
  - External pin to trapReq: SYNC_STAGES+2 cycles.
- Level-sensitive: a source held asserted after ack re-requests after cooldown if still takeable.

Decomposition:
- Shared package (RISC-V types): bit-index constants MIP_MEIP=11, MIP_MTIP=7, MIP_MSIP=3, MIP_SEIP=9, MIP_STIP=5, MIP_SSIP=1; the 12-bit interrupt vector typedef; IntCtrlState enum {IDLE, REQ, COOLDOWN}.
- Reuse the package's InterruptCode and Privilege enums.
- One sub-module: synchronizer (parameterised depth, async active-low reset), instantiated per external pin.
- Priority/takeable logic is a local function, not a module.

Test Plan:
- Reset, then privilege=Machine, mstatusMie=1, csrMie[7]=1, irqMachineTimer=1 at cycle 0 -> trapReq=1 at cycle 2, trapCode=4'h7, trapTarget=2'b11; trapAck at cycle 4 -> trapReq=0 at cycle 5, re-asserted at cycle 7 (timer still high, cooldown 1).
- irqMachineSoftware and irqMachineExternal both high, all enabled -> trapCode=4'hb. Drop external and ack -> next request trapCode=4'h3.
- privilege=Machine, mideleg[9]=1, csrMie[9]=1, irqSupervisorExternal high -> no trapReq. Switch privilege to User -> trapReq within 2 cycles, trapCode=4'h9, trapTarget=2'b01.
- In REQ with trapCode=4'h7, clear csrMie[7] without ack -> trapReq=0 next cycle, FSM IDLE. Repeat with trapAck in the same cycle -> COOLDOWN path, no withdraw.
- irqMachineExternal pulse with SYNC_STAGES=2 -> mip[11] set 3 cycles after the pin; trapReq 4 cycles after the pin.
- Assert rstN=0 mid-REQ, asynchronously between clock edges -> trapReq and mip clear immediately. After release, no request until sources are re-sampled (≥2 cycles).
